control_sequencer: RTL and testbench

- Ring-counter control unit for the SAP-style CPU. Steps through six T-states per instruction: T1 address, T2 increment, T3 memory fetch, T4–T6 execute.
- Drives the datapath load/enable lines from the current T-state and the one-hot outputs of the instruction decoder (lda, add, sub, out, active-low hlt).
- Latches a halt condition that stops the machine until reset.

---
 rtl/cpu_pkg.sv | 69 ++++++
 rtl/control_sequencer_ring_counter.sv | 42 ++++
 rtl/control_sequencer.sv | 132 +++++++++++++
 tb/tb_control_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the SAP-style CPU control path: T-state encodings,
// opcodes, control-word bit positions and the decode-priority helpers.
package cpu_pkg;

    // One-hot T-states; all-zero marks a halted machine.
    typedef enum logic [5:0] {
        T_HALT = 6'b000000,
        T1     = 6'b000001,
        T2     = 6'b000010,
        T3     = 6'b000100,
        T4     = 6'b001000,
        T5     = 6'b010000,
        T6     = 6'b100000
    } tstate_t;

    // Instruction opcodes as held in the IR upper nibble.
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control-word bit positions shared by sequencer, datapath and bench.
    localparam int CW_W  = 12;
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    // Resolved instruction after applying decode priority.
    typedef enum logic [2:0] {
        INS_NONE,
        INS_LDA,
        INS_ADD,
        INS_SUB,
        INS_OUT,
        INS_HLT
    } ins_t;

    // Priority hlt > out > sub > add > lda.
    function automatic ins_t decode_ins(input logic lda, input logic add,
                                        input logic sub, input logic out,
                                        input logic hlt_n);
        if (!hlt_n)   return INS_HLT;
        else if (out) return INS_OUT;
        else if (sub) return INS_SUB;
        else if (add) return INS_ADD;
        else if (lda) return INS_LDA;
        else          return INS_NONE;
    endfunction

    // True when more than one decode line is asserted.
    function automatic logic multi_active(input logic lda, input logic add,
                                          input logic sub, input logic out,
                                          input logic hlt_n);
        logic [2:0] n;
        n = 3'(lda) + 3'(add) + 3'(sub) + 3'(out) + 3'(!hlt_n);
        return n > 3'd1;
    endfunction

endpackage

// File: rtl/control_sequencer_ring_counter.sv
// Six-stage one-hot ring counter stepping the T-states.
//
//   state  | meaning
//   -------+------------------------------------------
//   T1     | address: PC onto bus, MAR load
//   T2     | PC increment
//   T3     | memory fetch into IR
//   T4..T6 | execute
//   T_HALT | all-zero, frozen until reset
module ring_counter
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load_t1,
    input  logic    freeze,
    output tstate_t t_state
);

    // Advance one T-state per cycle; freeze parks at all-zero, load_t1 cuts an instruction short.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_state <= T1;
        end else if (freeze) begin
            t_state <= T_HALT;
        end else if (load_t1) begin
            t_state <= T1;
        end else begin
            case (t_state)
                T1:      t_state <= T2;
                T2:      t_state <= T3;
                T3:      t_state <= T4;
                T4:      t_state <= T5;
                T5:      t_state <= T6;
                T6:      t_state <= T1;
                T_HALT:  t_state <= T_HALT;
                default: t_state <= T_HALT;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer for the SAP-style CPU: steps the ring counter and turns
// the current T-state plus decoder lines into datapath control strobes.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter bit SKIP_NOP = 1'b0
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lda,
    input  logic       add,
    input  logic       sub,
    input  logic       out,
    input  logic       hlt_n,
    output logic [5:0] t_state,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       halted,
    output logic       decode_err
);

    tstate_t         ts;
    ins_t            ins;
    logic            in_exec;
    logic            halt_now;
    logic            load_t1;
    logic [CW_W-1:0] cw;

    assign ins      = decode_ins(lda, add, sub, out, hlt_n);
    assign in_exec  = (ts == T4) || (ts == T5) || (ts == T6);
    assign halt_now = (ts == T4) && (ins == INS_HLT);

    // Early return to T1 once the instruction has no further active T-states.
    always_comb begin
        load_t1 = 1'b0;
        if (SKIP_NOP) begin
            if (ts == T4 && (ins == INS_OUT || ins == INS_NONE))
                load_t1 = 1'b1;
            if (ts == T5 && ins != INS_ADD && ins != INS_SUB)
                load_t1 = 1'b1;
        end
    end

    ring_counter u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_t1 (load_t1),
        .freeze  (halt_now || halted),
        .t_state (ts)
    );

    // Sticky halt and decode-conflict flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted     <= 1'b0;
            decode_err <= 1'b0;
        end else begin
            if (halt_now)
                halted <= 1'b1;
            if (in_exec && multi_active(lda, add, sub, out, hlt_n))
                decode_err <= 1'b1;
        end
    end

    // Microcode: fetch is fixed, execute depends on the prioritised decode.
    always_comb begin
        cw = '0;
        case (ts)
            T1: begin
                cw[CW_EP] = 1'b1;
                cw[CW_LM] = 1'b1;
            end
            T2: cw[CW_CP] = 1'b1;
            T3: begin
                cw[CW_CE] = 1'b1;
                cw[CW_LI] = 1'b1;
            end
            T4: begin
                if (ins == INS_LDA || ins == INS_ADD || ins == INS_SUB) begin
                    cw[CW_EI] = 1'b1;
                    cw[CW_LM] = 1'b1;
                end else if (ins == INS_OUT) begin
                    cw[CW_EA] = 1'b1;
                    cw[CW_LO] = 1'b1;
                end
            end
            T5: begin
                if (ins == INS_LDA) begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LA] = 1'b1;
                end else if (ins == INS_ADD || ins == INS_SUB) begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LB] = 1'b1;
                end
            end
            T6: begin
                if (ins == INS_ADD || ins == INS_SUB) begin
                    cw[CW_EU] = 1'b1;
                    cw[CW_LA] = 1'b1;
                    cw[CW_SU] = (ins == INS_SUB);
                end
            end
            default: cw = '0;
        endcase
    end

    assign t_state = ts;
    assign cp      = cw[CW_CP];
    assign ep      = cw[CW_EP];
    assign lm      = cw[CW_LM];
    assign ce      = cw[CW_CE];
    assign li      = cw[CW_LI];
    assign ei      = cw[CW_EI];
    assign la      = cw[CW_LA];
    assign ea      = cw[CW_EA];
    assign su      = cw[CW_SU];
    assign eu      = cw[CW_EU];
    assign lb      = cw[CW_LB];
    assign lo      = cw[CW_LO];

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: one instance per SKIP_NOP setting, both driven
// by the same decode lines and compared every cycle against a step-count model.
module tb_control_sequencer;

    localparam logic [11:0] CP = 12'h800;
    localparam logic [11:0] EP = 12'h400;
    localparam logic [11:0] LM = 12'h200;
    localparam logic [11:0] CE = 12'h100;
    localparam logic [11:0] LI = 12'h080;
    localparam logic [11:0] EI = 12'h040;
    localparam logic [11:0] LA = 12'h020;
    localparam logic [11:0] EA = 12'h010;
    localparam logic [11:0] SU = 12'h008;
    localparam logic [11:0] EU = 12'h004;
    localparam logic [11:0] LB = 12'h002;
    localparam logic [11:0] LO = 12'h001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, lda, add, sub, out, hlt_n;

    wire [5:0]  ts0, ts1;
    wire [11:0] cw0, cw1;
    wire        hl0, hl1, de0, de1;

    control_sequencer #(.SKIP_NOP(1'b0)) u_seq0 (
        .clk(clk), .rst_n(rst_n), .lda(lda), .add(add), .sub(sub), .out(out), .hlt_n(hlt_n),
        .t_state(ts0),
        .cp(cw0[11]), .ep(cw0[10]), .lm(cw0[9]), .ce(cw0[8]), .li(cw0[7]), .ei(cw0[6]),
        .la(cw0[5]), .ea(cw0[4]), .su(cw0[3]), .eu(cw0[2]), .lb(cw0[1]), .lo(cw0[0]),
        .halted(hl0), .decode_err(de0)
    );

    control_sequencer #(.SKIP_NOP(1'b1)) u_seq1 (
        .clk(clk), .rst_n(rst_n), .lda(lda), .add(add), .sub(sub), .out(out), .hlt_n(hlt_n),
        .t_state(ts1),
        .cp(cw1[11]), .ep(cw1[10]), .lm(cw1[9]), .ce(cw1[8]), .li(cw1[7]), .ei(cw1[6]),
        .la(cw1[5]), .ea(cw1[4]), .su(cw1[3]), .eu(cw1[2]), .lb(cw1[1]), .lo(cw1[0]),
        .halted(hl1), .decode_err(de1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: instruction step 1..6, plus sticky flags.
    int m_step [2];
    bit m_halt [2];
    bit m_err  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // 0 none, 1 lda, 2 add, 3 sub, 4 out, 5 hlt
    function automatic int cls_of();
        if (!hlt_n) return 5;
        if (out)    return 4;
        if (sub)    return 3;
        if (add)    return 2;
        if (lda)    return 1;
        return 0;
    endfunction

    function automatic int n_active();
        return int'(lda) + int'(add) + int'(sub) + int'(out) + int'(!hlt_n);
    endfunction

    function automatic int last_step(input int c);
        if (c == 1)           return 5;
        if (c == 2 || c == 3) return 6;
        return 4;
    endfunction

    function automatic logic [11:0] exp_cw(input int step, input bit h);
        int c;
        c = cls_of();
        if (h) return 12'h000;
        case (step)
            1: return EP | LM;
            2: return CP;
            3: return CE | LI;
            4: if (c >= 1 && c <= 3) return EI | LM;
               else if (c == 4)      return EA | LO;
               else                  return 12'h000;
            5: if (c == 1)                return CE | LA;
               else if (c == 2 || c == 3) return CE | LB;
               else                       return 12'h000;
            6: if (c == 2)      return EU | LA;
               else if (c == 3) return SU | EU | LA;
               else             return 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    task automatic advance(input int i);
        int c;
        c = cls_of();
        if (!rst_n) begin
            m_step[i] = 1;
            m_halt[i] = 1'b0;
            m_err[i]  = 1'b0;
        end else if (!m_halt[i]) begin
            if (m_step[i] >= 4 && n_active() > 1) m_err[i] = 1'b1;
            if (m_step[i] == 4 && c == 5)
                m_halt[i] = 1'b1;
            else if (i == 1 && m_step[i] >= 4 && m_step[i] >= last_step(c))
                m_step[i] = 1;
            else
                m_step[i] = (m_step[i] == 6) ? 1 : m_step[i] + 1;
        end
    endtask

    // Check both instances against the model, then take one clock edge.
    task automatic tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            logic [5:0]  ets;
            logic [5:0]  ats;
            logic [11:0] acw;
            logic        ahl, ade;
            ats = (i == 0) ? ts0 : ts1;
            acw = (i == 0) ? cw0 : cw1;
            ahl = (i == 0) ? hl0 : hl1;
            ade = (i == 0) ? de0 : de1;
            ets = m_halt[i] ? 6'd0 : 6'(1 << (m_step[i] - 1));
            chk($sformatf("t_state[%0d]", i), 32'(ats), 32'(ets));
            chk($sformatf("ctl[%0d]", i), 32'(acw), 32'(exp_cw(m_step[i], m_halt[i])));
            chk($sformatf("halted[%0d]", i), 32'(ahl), 32'(m_halt[i]));
            chk($sformatf("decode_err[%0d]", i), 32'(ade), 32'(m_err[i]));
        end
        @(posedge clk);
        advance(0);
        advance(1);
        @(negedge clk);
    endtask

    task automatic set_dec(input bit l, input bit a, input bit s, input bit o, input bit h);
        lda = l; add = a; sub = s; out = o; hlt_n = ~h;
    endtask

    task automatic rand_dec();
        int r;
        r = $urandom_range(0, 19);
        if (r <= 3)       set_dec(0, 0, 0, 0, 0);
        else if (r <= 6)  set_dec(1, 0, 0, 0, 0);
        else if (r <= 9)  set_dec(0, 1, 0, 0, 0);
        else if (r <= 12) set_dec(0, 0, 1, 0, 0);
        else if (r <= 15) set_dec(0, 0, 0, 1, 0);
        else if (r == 16) set_dec(0, 0, 0, 0, 1);
        else begin
            logic [4:0] b;
            b = 5'($urandom);
            set_dec(b[0], b[1], b[2], b[3], b[4]);
        end
    endtask

    task automatic reset_tick();
        rst_n = 1'b0;
        set_dec(0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
    endtask

    // Hold one instruction and count cycles until each instance is back at T1.
    task automatic measure(input string name, input bit l, input bit o, input int e0, input int e1);
        int len0, len1;
        len0 = 0;
        len1 = 0;
        reset_tick();
        set_dec(l, 0, 0, o, 0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (ts0 == 6'b000001 && len0 == 0) len0 = c;
            if (ts1 == 6'b000001 && len1 == 0) len1 = c;
        end
        chk({name, "_len_skip0"}, 32'(len0), 32'(e0));
        chk({name, "_len_skip1"}, 32'(len1), 32'(e1));
    endtask

    initial begin
        int halt_cnt;
        rst_n = 1'b0;
        set_dec(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_step[i] = 1;
            m_halt[i] = 1'b0;
            m_err[i]  = 1'b0;
        end
        @(negedge clk);
        chk("reset_ts", 32'(ts0), 32'h01);
        chk("reset_ctl", 32'(cw0), 32'(EP | LM));
        rst_n = 1'b1;

        // ADD then SUB through every T-state
        set_dec(0, 1, 0, 0, 0);
        repeat (6) tick();
        chk("add_wrap_ts", 32'(ts0), 32'h01);
        set_dec(0, 0, 1, 0, 0);
        repeat (5) tick();
        chk("sub_t6_ctl", 32'(cw0), 32'(SU | EU | LA));
        tick();

        // instruction lengths in both modes
        measure("lda",  1, 0, 6, 5);
        measure("out",  0, 1, 6, 4);
        measure("none", 0, 0, 6, 4);

        // halt and recovery
        reset_tick();
        set_dec(0, 0, 0, 0, 1);
        repeat (3) tick();
        chk("halt_t4_ctl", 32'(cw0), 32'h000);
        tick();
        chk("halt_ts", 32'({ts1, ts0}), 32'h000);
        for (int k = 0; k < 20; k++) begin
            rand_dec();
            tick();
        end
        chk("halt_hold", 32'({hl1, hl0}), 32'h3);
        reset_tick();
        chk("unhalt_ts", 32'({ts1, ts0}), 32'h041);
        chk("unhalt_flag", 32'({hl1, hl0}), 32'h0);

        // conflicting decode: ADD wins, error flag sticks until reset
        set_dec(1, 1, 0, 0, 0);
        repeat (3) tick();
        chk("prio_t4_ctl", 32'(cw0), 32'(EI | LM));
        repeat (3) tick();
        chk("err_set", 32'({de1, de0}), 32'h3);
        set_dec(1, 0, 0, 0, 0);
        repeat (12) tick();
        chk("err_sticky", 32'({de1, de0}), 32'h3);
        reset_tick();
        chk("err_clear", 32'({de1, de0}), 32'h0);

        // reset in T5 of ADD
        set_dec(0, 1, 0, 0, 0);
        repeat (4) tick();
        chk("pre_rst_t5", 32'(ts0), 32'h10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_t5_ts", 32'(ts0), 32'h01);
        chk("rst_t5_ctl", 32'(cw0), 32'(EP | LM));
        tick();
        chk("rst_t5_next_ts", 32'(ts0), 32'h02);
        chk("rst_t5_next_cp", 32'(cw0), 32'(CP));

        // randomized traffic with occasional resets
        halt_cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (hl0 || hl1) halt_cnt++;
            else halt_cnt = 0;
            if (halt_cnt > 12) begin
                rst_n = 1'b0;
                halt_cnt = 0;
            end
            rand_dec();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
